// File: rtl/line_buffer_feeder.sv
// line_buffer_feeder
//   Streams one IMG_WIDTH x IMG_HEIGHT frame out of a feature-map memory into a
//   KERNEL_SIZE-wide line buffer. A start pulse in IDLE launches a frame. One
//   read is issued per cycle unless hold is high. Every read pixel is forwarded
//   exactly one cycle later, tagged with its column/row position and with a
//   flag that says whether a full KxK window is now available.
//
//   Optional build macro: LINE_BUFFER_FEEDER_BASE_ADDR_EN
//     When defined, adds a base_addr input. It is latched on an accepted start
//     and added to the pixel index, wrapping modulo 2^ADDR_WIDTH.
//     When undefined, the base address is zero.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         frame request (accepted only in IDLE)
//   hold          backpressure: suppresses new reads while high
//   base_addr     frame base address (only with the macro)
//   mem_rd_en     memory read strobe
//   mem_addr      memory read address
//   mem_rd_data   read data, valid one cycle after mem_rd_en
//   enable        line-buffer shift strobe
//   data_out      pixel to the line buffer; holds its value when enable is low
//   col_idx       column of the pixel on data_out
//   row_idx       row of the pixel on data_out
//   window_valid  a complete KxK window exists after this shift
//   busy          frame in progress (READ or FLUSH)
//   done          one-cycle pulse, aligned with the final pixel's enable
module line_buffer_feeder #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned KERNEL_SIZE = 5,
    parameter int unsigned IMG_WIDTH   = 28,
    parameter int unsigned IMG_HEIGHT  = 28,
    parameter int unsigned ADDR_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hold,
`ifdef LINE_BUFFER_FEEDER_BASE_ADDR_EN
    input  logic [ADDR_WIDTH-1:0] base_addr,
`endif
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] col_idx,
    output logic [ADDR_WIDTH-1:0] row_idx,
    output logic                  window_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(NPIX - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IMG_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] K_EDGE   = ADDR_WIDTH'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FLUSH
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] pix;
    logic [ADDR_WIDTH-1:0] rd_col;    // position of the pixel read next
    logic [ADDR_WIDTH-1:0] rd_row;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] base_sel;
    logic [DATA_WIDTH-1:0] data_hold;
    logic                  accept;

`ifdef LINE_BUFFER_FEEDER_BASE_ADDR_EN
    assign base_sel = base_addr;
`else
    assign base_sel = '0;
`endif

    assign accept   = (state == IDLE) && start;
    assign mem_addr = base + pix;   // natural wrap modulo 2^ADDR_WIDTH

    // data_out follows the memory during an enable cycle and otherwise replays
    // the last forwarded pixel.
    assign data_out = enable ? mem_rd_data : data_hold;

    assign window_valid = enable && (row_idx >= K_EDGE) && (col_idx >= K_EDGE);

    always_comb begin
        state_next = state;
        mem_rd_en  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = READ;
            end
            READ: begin
                busy      = 1'b1;
                mem_rd_en = !hold;
                if (!hold && pix == LAST_PIX) state_next = FLUSH;
            end
            FLUSH: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // The position tags are captured alongside each read, so col_idx and
    // row_idx change at the same edge that raises enable for that pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable    <= 1'b0;
            data_hold <= '0;
            pix       <= '0;
            rd_col    <= '0;
            rd_row    <= '0;
            col_idx   <= '0;
            row_idx   <= '0;
            base      <= '0;
        end else begin
            enable    <= mem_rd_en;
            data_hold <= data_out;
            if (accept) begin
                pix     <= '0;
                rd_col  <= '0;
                rd_row  <= '0;
                col_idx <= '0;
                row_idx <= '0;
                base    <= base_sel;
            end else if (mem_rd_en) begin
                col_idx <= rd_col;
                row_idx <= rd_row;
                pix     <= (pix == LAST_PIX) ? '0 : pix + 1'b1;
                if (rd_col == LAST_COL) begin
                    rd_col <= '0;
                    rd_row <= (rd_row == LAST_ROW) ? '0 : rd_row + 1'b1;
                end else begin
                    rd_col <= rd_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_feeder.sv
module tb_line_buffer_feeder;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int K  = 3;
    localparam int N  = W * H;
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          hold;
`ifdef LINE_BUFFER_FEEDER_BASE_ADDR_EN
    logic [AW-1:0] base_addr;
`endif
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data;
    logic          enable;
    logic [DW-1:0] data_out;
    logic [AW-1:0] col_idx;
    logic [AW-1:0] row_idx;
    logic          window_valid;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    line_buffer_feeder #(
        .DATA_WIDTH (DW),
        .KERNEL_SIZE(K),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hold        (hold),
`ifdef LINE_BUFFER_FEEDER_BASE_ADDR_EN
        .base_addr   (base_addr),
`endif
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .enable      (enable),
        .data_out    (data_out),
        .col_idx     (col_idx),
        .row_idx     (row_idx),
        .window_valid(window_valid),
        .busy        (busy),
        .done        (done)
    );

    // Feature-map memory: one-cycle read latency.
    logic [DW-1:0] mem [0:MEMSZ-1];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: frame progress expressed as counts of reads and emits.
    bit            m_reading;
    bit            m_flush;
    bit            m_prev_rd;
    int            m_reads;
    int            m_emits;
    int            m_base;
    logic [DW-1:0] m_last;
    int            cur_base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_reading = 0;
        m_flush   = 0;
        m_prev_rd = 0;
        m_reads   = 0;
        m_emits   = 0;
        m_base    = 0;
        m_last    = '0;
    endtask

    function automatic int eff_base(input int b);
`ifdef LINE_BUFFER_FEEDER_BASE_ADDR_EN
        return b % MEMSZ;
`else
        return 0 * b;
`endif
    endfunction

    // Compare DUT against the model for the current cycle, then advance the model.
    task automatic model_step();
        bit e_rd, e_en, was_idle;
        int c, r;
        e_rd = m_reading && !hold;
        e_en = m_prev_rd;
        chk("mem_rd_en", mem_rd_en, e_rd);
        if (e_rd) chk("mem_addr", mem_addr, (m_base + m_reads) % MEMSZ);
        chk("enable", enable, e_en);
        chk("busy", busy, m_reading || m_flush);
        chk("done", done, m_flush);
        if (e_en) begin
            c = m_emits % W;
            r = m_emits / W;
            m_last = mem[(m_base + m_emits) % MEMSZ];
            chk("col_idx", col_idx, c);
            chk("row_idx", row_idx, r);
            chk("window_valid", window_valid, (r >= K - 1) && (c >= K - 1));
        end else begin
            chk("window_valid_idle", window_valid, 0);
        end
        chk("data_out", data_out, m_last);

        was_idle = !m_reading && !m_flush;
        m_flush  = 0;
        if (e_rd) begin
            m_reads++;
            if (m_reads == N) begin
                m_reading = 0;
                m_flush   = 1;
            end
        end
        if (e_en) m_emits++;
        m_prev_rd = e_rd;
        if (start && was_idle) begin
            m_reading = 1;
            m_reads   = 0;
            m_emits   = 0;
            m_base    = eff_base(cur_base);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_rd_en"}, mem_rd_en, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_enable"}, enable, 0);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_col_idx"}, col_idx, 0);
        chk({tag, "_row_idx"}, row_idx, 0);
        chk({tag, "_window_valid"}, window_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic drive_base(input int b);
        cur_base = b;
`ifdef LINE_BUFFER_FEEDER_BASE_ADDR_EN
        base_addr = AW'(b);
`endif
    endtask

    // One frame: start in the first cycle, optional hold burst, optional
    // start while busy, optional reset at a given read count.
    task automatic run_frame(input int b, input int hold_at, input int hold_len,
                             input int start_at, input int rst_at, input bit rnd_hold);
        int  held = 0, en_cnt = 0, done_cnt = 0, wv_cnt = 0, cyc = 0;
        bit  aborted = 0, finished = 0, was_flush;
        drive_base(b);
        while (!finished && cyc < 300) begin
            @(posedge clk); #1;
            rst   = 0;
            start = (cyc == 0);
            hold  = 0;
            if (m_reading) begin
                if (rnd_hold) hold = ($urandom_range(0, 3) == 0);
                else if (m_reads == hold_at && held < hold_len) begin
                    hold = 1;
                    held++;
                end
                if (m_reads == start_at) start = 1;
                if (m_reads == rst_at) rst = 1;
            end
            #1;
            if (rst) begin
                check_all_zero("rst_mid");
                model_reset();
                aborted  = 1;
                finished = 1;
            end else begin
                en_cnt   += int'(enable);
                done_cnt += int'(done);
                wv_cnt   += int'(window_valid);
                was_flush = m_flush;
                model_step();
                if (was_flush) finished = 1;
            end
            cyc++;
        end
        chk("frame_timeout", finished, 1);
        if (!aborted) begin
            chk("enable_count", en_cnt, N);
            chk("done_count", done_cnt, 1);
            chk("window_count", wv_cnt, (H - K + 1) * (W - K + 1));
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst   = 0;
            start = 0;
            hold  = 1'($urandom_range(0, 1));
            #1;
            model_step();
        end
    endtask

    initial begin
        rst   = 1;
        start = 0;
        hold  = 0;
        drive_base(0);
        for (int i = 0; i < MEMSZ; i++) mem[i] = DW'($urandom);
        model_reset();

        @(posedge clk); @(posedge clk); #2;
        check_all_zero("reset");

        idle_cycles(2);
        run_frame(100, -1, 0, -1, -1, 0);   // plain frame
        run_frame(100, 6, 3, -1, -1, 0);    // hold 3 cycles after addr 5
        run_frame(7, -1, 0, 7, -1, 0);      // start while busy
        run_frame(0, -1, 0, -1, 9, 0);      // reset mid-frame
        idle_cycles(3);
        run_frame(0, -1, 0, -1, -1, 0);     // restart after reset
        run_frame(1020, -1, 0, -1, -1, 0);  // address wrap when base is enabled
        for (int f = 0; f < 4; f++) begin
            run_frame(int'($urandom_range(0, MEMSZ - 1)), -1, 0, -1, -1, 1);
            if (f[0]) idle_cycles(2);
        end
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_buffer_feeder.md
LINE_BUFFER_FEEDER -- requirements
Module: line_buffer_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, pixel width in bits.
REQ-002 Parameter KERNEL_SIZE, default 5, convolution window edge.
REQ-003 Parameter IMG_WIDTH, default 28, pixels per row.
REQ-004 Parameter IMG_HEIGHT, default 28, rows per frame.
REQ-005 Parameter ADDR_WIDTH, default 10, memory address width; must satisfy 2^ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT.
REQ-006 Clocking: one clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 start  input  1  single-cycle frame request; honoured only in IDLE.
REQ-010 hold  input  1  backpressure; when high, no new memory read is issued.
REQ-011 mem_rd_en  output  1  feature-map memory read strobe.
REQ-012 mem_addr  output  ADDR_WIDTH  read address.
REQ-013 mem_rd_data  input  DATA_WIDTH  read data, valid 1 cycle after mem_rd_en.
REQ-014 enable  output  1  shift strobe to the line buffer.
REQ-015 data_out  output  DATA_WIDTH  pixel to the line buffer, qualified by enable.
REQ-016 col_idx  output  ADDR_WIDTH  column of the pixel currently on data_out.
REQ-017 row_idx  output  ADDR_WIDTH  row of the pixel currently on data_out.
REQ-018 window_valid  output  1  high when the line buffer holds a complete KxK window after this shift.
REQ-019 busy  output  1  high in READ and FLUSH.
REQ-020 done  output  1  one-cycle pulse at frame end.

Function
REQ-021 FSM states: IDLE, READ, FLUSH; IDLE->READ on start, READ->FLUSH when the read of pixel IMG_WIDTH*IMG_HEIGHT-1 is issued, FLUSH->IDLE after one cycle.
REQ-022 In READ, each cycle with hold low: mem_rd_en=1, mem_addr=base+pix, pix increments by 1; with hold high: mem_rd_en=0, pix unchanged.
REQ-023 enable in cycle t+1 equals mem_rd_en in cycle t (fixed 1-cycle latency); data_out=mem_rd_data whenever enable=1, and is held otherwise.
REQ-024 A read issued in the cycle hold rises is still emitted in the following cycle.
REQ-025 col_idx/row_idx advance only on enable; col wraps IMG_WIDTH-1->0 with row+1.
REQ-026 window_valid = enable AND row_idx >= KERNEL_SIZE-1 AND col_idx >= KERNEL_SIZE-1.
REQ-027 done pulses in the FLUSH cycle, coinciding with enable for the final pixel.
REQ-028 start while busy is ignored; start in the cycle after done begins a new frame with pix, col, row restarted at 0.
REQ-029 Last pixel of a frame: col_idx=IMG_WIDTH-1, row_idx=IMG_HEIGHT-1.

Reset
REQ-030 rst asserted forces IDLE immediately and zeroes mem_rd_en, mem_addr, enable, data_out, col_idx, row_idx, window_valid, busy, done, pix.
REQ-031 Reset mid-frame abandons the frame; no done is generated; the next frame requires a new start.

Configuration
REQ-032 Macro LINE_BUFFER_FEEDER_BASE_ADDR_EN defined: extra input base_addr [ADDR_WIDTH] is latched on an accepted start and added to pix (modulo 2^ADDR_WIDTH); undefined: no base_addr port, base=0.

Verification
REQ-033 IMG 4x4, K=3, start at cycle 0, hold=0 -> mem_rd_en cycles 1-16 with addr 0..15, enable cycles 2-17, done at cycle 17 only.
REQ-034 Same config -> window_valid high exactly for (row,col) in {2,3}x{2,3}, 4 pulses total.
REQ-035 hold high for 3 cycles after addr 5 -> addr 5 data still emitted, no reads for 3 cycles, addresses 6..15 follow contiguously, total 16 enables.
REQ-036 start pulsed during busy at pixel 7 -> ignored, single done, 16 enables.
REQ-037 rst asserted at pixel 9 -> all outputs 0 same cycle, no done; new start -> addr restarts at 0.
REQ-038 With LINE_BUFFER_FEEDER_BASE_ADDR_EN, base_addr=100 -> addresses 100..115; base_addr=1020, ADDR_WIDTH=10 -> wraps 1020..1023, 0..11.
